// File: rtl/vdot_pkg.sv
// Shared encodings, FSM state type and lane-count helper for the VDOT sequencer.
package vdot_pkg;

  localparam logic [6:0] OP_VDOT = 7'b0101011;

  localparam logic [2:0] EW8  = 3'd0;
  localparam logic [2:0] EW16 = 3'd1;
  localparam logic [2:0] EW32 = 3'd2;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_REQ_A  = 3'd1,
    S_WAIT_A = 3'd2,
    S_REQ_B  = 3'd3,
    S_WAIT_B = 3'd4,
    S_MAC    = 3'd5,
    S_DONE   = 3'd6
  } state_t;

  function automatic int unsigned lanes_for(input logic [2:0] width, input int unsigned xlen);
    case (width)
      EW8:     return xlen / 8;
      EW16:    return xlen / 16;
      default: return xlen / 32;
    endcase
  endfunction

endpackage

// File: rtl/vdot_lane_mac.sv
// Combinational signed multiply-sum of the first i_k packed elements of two words.
// Element 0 sits in the LSBs; lanes at or above i_k contribute nothing.
module vdot_lane_mac
  import vdot_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int LEN_W = 7,
  parameter int SUMW  = XLEN + LEN_W
) (
  input  logic [XLEN-1:0]        i_a,
  input  logic [XLEN-1:0]        i_b,
  input  logic [2:0]             i_width,
  input  logic [LEN_W-1:0]       i_k,
  output logic signed [SUMW-1:0] o_sum
);

  logic signed [15:0] w_p8;
  logic signed [31:0] w_p16;
  logic signed [63:0] w_p32;

  always_comb begin
    o_sum = '0;
    w_p8  = '0;
    w_p16 = '0;
    w_p32 = '0;
    for (int i = 0; i < XLEN / 8; i++) begin
      if (i_width == EW8 && i < int'(i_k)) begin
        w_p8  = $signed(i_a[i*8 +: 8]) * $signed(i_b[i*8 +: 8]);
        o_sum = o_sum + SUMW'(w_p8);
      end
    end
    for (int i = 0; i < XLEN / 16; i++) begin
      if (i_width == EW16 && i < int'(i_k)) begin
        w_p16 = $signed(i_a[i*16 +: 16]) * $signed(i_b[i*16 +: 16]);
        o_sum = o_sum + SUMW'(w_p16);
      end
    end
    for (int i = 0; i < XLEN / 32; i++) begin
      if (i_width == EW32 && i < int'(i_k)) begin
        w_p32 = $signed(i_a[i*32 +: 32]) * $signed(i_b[i*32 +: 32]);
        o_sum = o_sum + SUMW'(w_p32);
      end
    end
  end

endmodule

// File: rtl/vdot_seq_ctrl.sv
// Multi-cycle VDOT sequencer: fetches A/B words, accumulates signed lane products, one write-back.
// Define VDOT_SAT_EN for saturating accumulation with a sticky sat_o flag.
module vdot_seq_ctrl
  import vdot_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int LEN_W  = 7,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inst_valid,
  input  logic [31:0]       inst,
  input  logic [XLEN-1:0]   rs1_val,
  input  logic [XLEN-1:0]   rs2_val,
  output logic              inst_ready,
  output logic              stall,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [XLEN-1:0]   mem_rdata,
  output logic              wb_valid,
  output logic [4:0]        wb_rd,
  output logic [XLEN-1:0]   wb_data,
  output logic              illegal
`ifdef VDOT_SAT_EN
  , output logic            sat_o
`endif
);

  // Saturation needs the untruncated products to see the true overflow.
`ifdef VDOT_SAT_EN
  localparam int SUMW = 2 * XLEN + LEN_W;
`else
  localparam int SUMW = XLEN + LEN_W;
`endif

  state_t            r_state, w_next;
  logic [4:0]        r_rd;
  logic [2:0]        r_width;
  logic [LEN_W-1:0]  r_rem;
  logic [ADDR_W-1:0] r_addr_a, r_addr_b;
  logic [XLEN-1:0]   r_word_a, r_word_b, r_acc;
  logic              r_ill;

  logic                   w_accept, w_bad;
  logic [LEN_W-1:0]       w_n, w_lanes, w_k, w_rem_nxt;
  logic signed [SUMW-1:0] w_sum;
  logic [XLEN-1:0]        w_acc_nxt;
  logic                   w_unused;

  assign w_unused  = ^inst[24:15];
  assign w_accept  = inst_valid && (inst[6:0] == OP_VDOT) && (r_state == S_IDLE);
  assign w_bad     = (inst[14:12] > EW32) || (rs1_val[1:0] != 2'b00) || (rs2_val[1:0] != 2'b00);
  assign w_n       = LEN_W'(inst[31:25]);
  assign w_lanes   = LEN_W'(lanes_for(r_width, XLEN));
  assign w_k       = (r_rem < w_lanes) ? r_rem : w_lanes;
  assign w_rem_nxt = r_rem - w_k;

  vdot_lane_mac #(.XLEN(XLEN), .LEN_W(LEN_W), .SUMW(SUMW)) u_mac (
    .i_a     (r_word_a),
    .i_b     (r_word_b),
    .i_width (r_width),
    .i_k     (w_k),
    .o_sum   (w_sum)
  );

`ifdef VDOT_SAT_EN
  logic               r_sat;
  logic               w_ovf;
  logic signed [SUMW:0] w_wide, w_max, w_min;

  assign w_max  = {{(SUMW + 2 - XLEN){1'b0}}, {(XLEN - 1){1'b1}}};
  assign w_min  = {{(SUMW + 2 - XLEN){1'b1}}, {(XLEN - 1){1'b0}}};
  assign w_wide = {{(SUMW + 1 - XLEN){r_acc[XLEN-1]}}, r_acc} + {w_sum[SUMW-1], w_sum};

  always_comb begin
    w_ovf     = 1'b0;
    w_acc_nxt = w_wide[XLEN-1:0];
    if (w_wide > w_max) begin
      w_ovf     = 1'b1;
      w_acc_nxt = w_max[XLEN-1:0];
    end else if (w_wide < w_min) begin
      w_ovf     = 1'b1;
      w_acc_nxt = w_min[XLEN-1:0];
    end
  end

  assign sat_o = r_sat && wb_valid;
`else
  assign w_acc_nxt = r_acc + w_sum[XLEN-1:0];
`endif

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_accept) w_next = (w_bad || w_n == '0) ? S_DONE : S_REQ_A;
      S_REQ_A:  if (mem_gnt) w_next = S_WAIT_A;
      S_WAIT_A: if (mem_rvalid) w_next = S_REQ_B;
      S_REQ_B:  if (mem_gnt) w_next = S_WAIT_B;
      S_WAIT_B: if (mem_rvalid) w_next = S_MAC;
      S_MAC:    w_next = (w_rem_nxt == '0) ? S_DONE : S_REQ_A;
      default:  w_next = S_IDLE;
    endcase
  end

  always_comb begin
    mem_req    = (r_state == S_REQ_A) || (r_state == S_REQ_B);
    mem_addr   = '0;
    if (r_state == S_REQ_A) mem_addr = r_addr_a;
    if (r_state == S_REQ_B) mem_addr = r_addr_b;
    inst_ready = (r_state == S_IDLE);
    stall      = (inst_valid && inst[6:0] == OP_VDOT && r_state == S_IDLE)
              || (r_state != S_IDLE && r_state != S_DONE);
    wb_valid   = (r_state == S_DONE) && !r_ill;
    illegal    = (r_state == S_DONE) && r_ill;
    wb_rd      = r_rd;
    wb_data    = r_acc;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_rd     <= '0;
      r_width  <= '0;
      r_rem    <= '0;
      r_addr_a <= '0;
      r_addr_b <= '0;
      r_word_a <= '0;
      r_word_b <= '0;
      r_acc    <= '0;
      r_ill    <= 1'b0;
`ifdef VDOT_SAT_EN
      r_sat    <= 1'b0;
`endif
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: if (w_accept) begin
          r_rd     <= inst[11:7];
          r_width  <= inst[14:12];
          r_rem    <= w_n;
          r_addr_a <= ADDR_W'(rs1_val);
          r_addr_b <= ADDR_W'(rs2_val);
          r_acc    <= '0;
          r_ill    <= w_bad;
`ifdef VDOT_SAT_EN
          r_sat    <= 1'b0;
`endif
        end
        S_WAIT_A: if (mem_rvalid) r_word_a <= mem_rdata;
        S_WAIT_B: if (mem_rvalid) r_word_b <= mem_rdata;
        S_MAC: begin
          r_acc    <= w_acc_nxt;
          r_rem    <= w_rem_nxt;
          r_addr_a <= r_addr_a + ADDR_W'(4);
          r_addr_b <= r_addr_b + ADDR_W'(4);
`ifdef VDOT_SAT_EN
          r_sat    <= r_sat | w_ovf;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_vdot_seq_ctrl.sv
// Directed, table-driven bench for vdot_seq_ctrl with a simple word-memory model.
module tb_vdot_seq_ctrl;

`ifdef VDOT_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_valid;
  logic [31:0] inst, rs1_val, rs2_val;
  logic        inst_ready, stall, mem_req, mem_gnt, mem_rvalid;
  logic [31:0] mem_addr, mem_rdata, wb_data;
  logic        wb_valid, illegal;
  logic [4:0]  wb_rd;
`ifdef VDOT_SAT_EN
  logic        sat_o;
`endif

  always #5 clk = ~clk;

  vdot_seq_ctrl #(.XLEN(32), .LEN_W(7), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .inst_valid(inst_valid), .inst(inst),
    .rs1_val(rs1_val), .rs2_val(rs2_val), .inst_ready(inst_ready), .stall(stall),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .illegal(illegal)
`ifdef VDOT_SAT_EN
    , .sat_o(sat_o)
`endif
  );

  // Memory model: grant in the request cycle unless blocked, data one cycle later.
  logic [31:0] mem [0:255];
  logic        gnt_block, rv_model, rv_inject;
  logic [31:0] blk_addr, rd_model;

  assign mem_gnt    = mem_req && !(gnt_block && mem_addr == blk_addr);
  assign mem_rvalid = rv_model | rv_inject;
  assign mem_rdata  = rd_model;

  always @(posedge clk) begin
    if (rst) rv_model <= 1'b0;
    else     rv_model <= mem_req && mem_gnt;
    rd_model <= mem[mem_addr[9:2]];
  end

  typedef struct {
    logic [31:0] inst;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        exp_ill;
    logic [31:0] exp_data;
    logic        exp_sat;
    int          words;
  } vec_t;

  vec_t tbl[10];
  int   n_cmp = 0;
  int   n_err = 0;

  function automatic logic [31:0] mk(input int n, input int f3, input int rd);
    return {7'(n), 10'd0, 3'(f3), 5'(rd), 7'b0101011};
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int          lat, reqs;
    bit          done, stall_ok;
    logic        got_ill;
    logic [31:0] got_data;
    logic [4:0]  got_rd;
    logic        got_sat;
    got_ill = 1'b0; got_data = '0; got_rd = '0; got_sat = 1'b0;
    @(negedge clk);
    inst_valid = 1'b1; inst = v.inst; rs1_val = v.rs1; rs2_val = v.rs2;
    #1;
    chk($sformatf("v%0d accept_stall", idx), 32'(stall), 32'd1);
    chk($sformatf("v%0d accept_ready", idx), 32'(inst_ready), 32'd1);
    @(posedge clk);
    lat = 0; reqs = 0; done = 1'b0; stall_ok = 1'b1;
    while (!done && lat < 200) begin
      @(negedge clk);
      inst_valid = 1'b0;
      #1;
      lat++;
      if (mem_req) reqs++;
      if (wb_valid || illegal) begin
        done     = 1'b1;
        got_ill  = illegal;
        got_data = wb_data;
        got_rd   = wb_rd;
        if (stall) stall_ok = 1'b0;
`ifdef VDOT_SAT_EN
        got_sat  = sat_o;
`endif
      end else if (!stall) begin
        stall_ok = 1'b0;
      end
    end
    chk($sformatf("v%0d completion", idx), 32'(done), 32'd1);
    if (done) begin
      chk($sformatf("v%0d illegal", idx), 32'(got_ill), 32'(v.exp_ill));
      if (!v.exp_ill) chk($sformatf("v%0d wb_data", idx), got_data, v.exp_data);
      chk($sformatf("v%0d wb_rd", idx), 32'(got_rd), 32'(v.inst[11:7]));
      chk($sformatf("v%0d latency", idx), 32'(lat), 32'(5 * v.words + 1));
      chk($sformatf("v%0d mem_reqs", idx), 32'(reqs), 32'(2 * v.words));
      chk($sformatf("v%0d stall_profile", idx), 32'(stall_ok), 32'd1);
      if (SAT) chk($sformatf("v%0d sat", idx), 32'(got_sat), 32'(v.exp_sat));
    end
    @(negedge clk);
    #1;
    chk($sformatf("v%0d pulse_end", idx), 32'({wb_valid, illegal}), 32'd0);
    chk($sformatf("v%0d ready_after", idx), 32'(inst_ready), 32'd1);
  endtask

  initial begin
    int  seen;
    bit  quiet;
    rst = 1'b1; inst_valid = 1'b0; inst = '0; rs1_val = '0; rs2_val = '0;
    gnt_block = 1'b0; blk_addr = '0; rv_inject = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 32'hDEAD0000 + 32'(i);
    mem[32'h100 >> 2] = 32'h04030201; mem[32'h200 >> 2] = 32'h01010101;
    mem[32'h110 >> 2] = 32'hFFFF0002; mem[32'h114 >> 2] = 32'h00000003;
    mem[32'h210 >> 2] = 32'h00050004; mem[32'h214 >> 2] = 32'h00000002;
    mem[32'h120 >> 2] = 32'h7FFFFFFF; mem[32'h124 >> 2] = 32'h7FFFFFFF;
    mem[32'h220 >> 2] = 32'h7FFFFFFF; mem[32'h224 >> 2] = 32'h7FFFFFFF;
    mem[32'h130 >> 2] = 32'h80FF0302; mem[32'h134 >> 2] = 32'h555555FE;
    mem[32'h230 >> 2] = 32'h7F020101; mem[32'h234 >> 2] = 32'h77777703;
    mem[32'h140 >> 2] = 32'h80008000; mem[32'h240 >> 2] = 32'h80008000;

    tbl[0] = '{mk(4, 0, 5),  32'h100,  32'h200, 1'b0, 32'd10, 1'b0, 1};
    tbl[1] = '{mk(3, 1, 10), 32'h110,  32'h210, 1'b0, 32'd9, 1'b0, 2};
    tbl[2] = '{mk(4, 3, 9),  32'h100,  32'h200, 1'b1, 32'd0, 1'b0, 0};
    tbl[3] = '{mk(4, 0, 9),  32'h1002, 32'h200, 1'b1, 32'd0, 1'b0, 0};
    tbl[4] = '{mk(4, 0, 8),  32'h100,  32'h201, 1'b1, 32'd0, 1'b0, 0};
    tbl[5] = '{mk(0, 5, 3),  32'h100,  32'h200, 1'b1, 32'd0, 1'b0, 0};
    tbl[6] = '{mk(0, 1, 12), 32'h100,  32'h200, 1'b0, 32'd0, 1'b0, 0};
    tbl[7] = '{mk(2, 2, 31), 32'h120,  32'h220, 1'b0, SAT ? 32'h7FFFFFFF : 32'h00000002, SAT, 2};
    tbl[8] = '{mk(5, 0, 1),  32'h130,  32'h230, 1'b0, 32'hFFFFC07D, 1'b0, 2};
    tbl[9] = '{mk(2, 1, 17), 32'h140,  32'h240, 1'b0, SAT ? 32'h7FFFFFFF : 32'h80000000, SAT, 1};

    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst inst_ready", 32'(inst_ready), 32'd1);
    chk("rst outputs", 32'({stall, mem_req, wb_valid, illegal}), 32'd0);
    chk("rst wb_data", wb_data, 32'd0);
    chk("rst mem_addr", mem_addr, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) run_vec(tbl[i], i);

    // Grant withheld in REQ_B, then reset lands in WAIT_B.
    gnt_block = 1'b1; blk_addr = 32'h200;
    @(negedge clk);
    inst_valid = 1'b1; inst = mk(4, 0, 7); rs1_val = 32'h100; rs2_val = 32'h200;
    @(posedge clk);
    seen = 0;
    for (int c = 0; c < 50 && seen == 0; c++) begin
      @(negedge clk);
      inst_valid = 1'b0;
      #1;
      if (mem_req && mem_addr == 32'h200) seen = 1;
    end
    chk("reqb reached", 32'(seen), 32'd1);
    for (int j = 0; j < 2; j++) begin
      @(negedge clk);
      #1;
      chk($sformatf("reqb hold%0d req", j), 32'(mem_req), 32'd1);
      chk($sformatf("reqb hold%0d addr", j), mem_addr, 32'h200);
    end
    gnt_block = 1'b0;
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("waitb stall", 32'({stall, mem_req}), 32'b10);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("abort mem_req", 32'(mem_req), 32'd0);
    chk("abort idle", 32'({inst_ready, stall}), 32'b10);
    @(negedge clk);
    rst = 1'b0; rv_inject = 1'b1;
    quiet = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      rv_inject = 1'b0;
      #1;
      if (wb_valid || illegal || mem_req || !inst_ready || stall) quiet = 1'b0;
    end
    chk("post-reset quiet", 32'(quiet), 32'd1);
    run_vec(tbl[1], 10);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
